// File: rtl/mrsp_access_ctrl.sv
// Access sequencer/arbiter for the shared 16-bit MRSP register: one word store via
// STO_A/A_IN or a byte pair via STO/A0/D_IN, with round-robin arbitration and HOLD.
module mrsp_access_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             nRESET,
    input  logic             W_REQ,
    input  logic [15:0]      W_DATA,
    output logic             W_ACK,
    input  logic             B_REQ,
    input  logic [15:0]      B_DATA,
    input  logic             B_ORDER,
    output logic             B_ACK,
    input  logic             HOLD,
    output logic [15:0]      D_IN,
    output logic             A0,
    output logic             STO,
    output logic             STO_A,
    output logic [15:0]      A_IN,
    output logic             BUSY,
    output logic             LAST_GNT,
    output logic [CNT_W-1:0] TXN_CNT
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WORD  = 2'd1,
        BYTE1 = 2'd2,
        BYTE2 = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      word_q, word_d;
    logic [15:0]      bdata_q, bdata_d;
    logic             border_q, border_d;
    logic             last_gnt_q, last_gnt_d;
    logic [CNT_W-1:0] txn_cnt_q, txn_cnt_d;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q    <= IDLE;
            word_q     <= '0;
            bdata_q    <= '0;
            border_q   <= 1'b0;
            last_gnt_q <= 1'b1;
            txn_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            bdata_q    <= bdata_d;
            border_q   <= border_d;
            last_gnt_q <= last_gnt_d;
            txn_cnt_q  <= txn_cnt_d;
        end
    end

    logic grant_w;
    logic grant_b;

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        bdata_d    = bdata_q;
        border_d   = border_q;
        last_gnt_d = last_gnt_q;
        txn_cnt_d  = txn_cnt_q;
        // On a tie the requester not granted last time wins.
        grant_w    = W_REQ && (!B_REQ || last_gnt_q);
        grant_b    = B_REQ && (!W_REQ || !last_gnt_q);
        if (!HOLD) begin
            unique case (state_q)
                IDLE: begin
                    if (grant_w) begin
                        state_d    = WORD;
                        word_d     = W_DATA;
                        last_gnt_d = 1'b0;
                    end else if (grant_b) begin
                        state_d    = BYTE1;
                        bdata_d    = B_DATA;
                        border_d   = B_ORDER;
                        last_gnt_d = 1'b1;
                    end
                end
                WORD: begin
                    state_d   = IDLE;
                    txn_cnt_d = txn_cnt_q + CNT_W'(1);
                end
                BYTE1: state_d = BYTE2;
                BYTE2: begin
                    state_d   = IDLE;
                    txn_cnt_d = txn_cnt_q + CNT_W'(1);
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outside BYTE1 the selected byte is the second one, so D_IN keeps its last value in IDLE.
    logic sel_hi;

    always_comb begin
        sel_hi   = (state_q == BYTE1) ? border_q : ~border_q;
        D_IN     = {8'h00, sel_hi ? bdata_q[15:8] : bdata_q[7:0]};
        A_IN     = word_q;
        STO_A    = (state_q == WORD) && !HOLD;
        W_ACK    = (state_q == WORD) && !HOLD;
        STO      = ((state_q == BYTE1) || (state_q == BYTE2)) && !HOLD;
        A0       = ((state_q == BYTE1) || (state_q == BYTE2)) && !HOLD && sel_hi;
        B_ACK    = (state_q == BYTE2) && !HOLD;
        BUSY     = (state_q != IDLE);
        LAST_GNT = last_gnt_q;
        TXN_CNT  = txn_cnt_q;
    end

endmodule

// File: tb/tb_mrsp_access_ctrl.sv
// Bench for mrsp_access_ctrl: directed scenarios plus random traffic against a
// queue-of-strobe-cycles reference model.
module tb_mrsp_access_ctrl;
    localparam int CNT_W = 8;

    logic             CLK = 1'b0;
    logic             nRESET;
    logic             W_REQ, B_REQ, B_ORDER, HOLD;
    logic [15:0]      W_DATA, B_DATA;
    logic             W_ACK, B_ACK, A0, STO, STO_A, BUSY, LAST_GNT;
    logic [15:0]      D_IN, A_IN;
    logic [CNT_W-1:0] TXN_CNT;

    mrsp_access_ctrl #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRESET(nRESET),
        .W_REQ(W_REQ), .W_DATA(W_DATA), .W_ACK(W_ACK),
        .B_REQ(B_REQ), .B_DATA(B_DATA), .B_ORDER(B_ORDER), .B_ACK(B_ACK),
        .HOLD(HOLD), .D_IN(D_IN), .A0(A0), .STO(STO), .STO_A(STO_A),
        .A_IN(A_IN), .BUSY(BUSY), .LAST_GNT(LAST_GNT), .TXN_CNT(TXN_CNT)
    );

    always #5 CLK = ~CLK;

    // One entry per future strobe cycle of the transaction in progress.
    typedef struct {
        bit          sto, sto_a, a0, w_ack, b_ack;
        logic [15:0] d_in, a_in;
    } slot_t;

    slot_t       q[$];
    logic [15:0] m_din, m_ain;
    bit          m_last;
    int          m_cnt;
    bit          w_pend, b_pend;
    int          tests = 0;
    int          fails = 0;

    function automatic slot_t mk(bit sto, bit sto_a, bit a0, bit w_ack, bit b_ack,
                                 logic [15:0] d_in, logic [15:0] a_in);
        slot_t s;
        s.sto = sto; s.sto_a = sto_a; s.a0 = a0; s.w_ack = w_ack; s.b_ack = b_ack;
        s.d_in = d_in; s.a_in = a_in;
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_din  = '0;
        m_ain  = '0;
        m_last = 1'b1;
        m_cnt  = 0;
    endtask

    task automatic model_step();
        slot_t s;
        logic [15:0] hi, lo;
        if (HOLD) return;
        if (q.size() > 0) begin
            s = q.pop_front();
            m_din = s.d_in;
            m_ain = s.a_in;
            if (s.w_ack || s.b_ack) m_cnt = (m_cnt + 1) % (1 << CNT_W);
            if (s.w_ack) w_pend = 1'b0;
            if (s.b_ack) b_pend = 1'b0;
        end else if (W_REQ && (!B_REQ || m_last)) begin
            m_last = 1'b0;
            q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, m_din, W_DATA));
        end else if (B_REQ) begin
            m_last = 1'b1;
            hi = {8'h00, B_DATA[15:8]};
            lo = {8'h00, B_DATA[7:0]};
            q.push_back(mk(1'b1, 1'b0, B_ORDER, 1'b0, 1'b0, B_ORDER ? hi : lo, m_ain));
            q.push_back(mk(1'b1, 1'b0, !B_ORDER, 1'b0, 1'b1, B_ORDER ? lo : hi, m_ain));
        end
    endtask

    task automatic check_outputs(input string ph);
        slot_t e;
        bit    busy;
        if (q.size() > 0) begin
            e = q[0];
            busy = 1'b1;
        end else begin
            e = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_din, m_ain);
            busy = 1'b0;
        end
        chk({ph, ":STO"},      32'(STO),      32'(e.sto & !HOLD));
        chk({ph, ":STO_A"},    32'(STO_A),    32'(e.sto_a & !HOLD));
        chk({ph, ":A0"},       32'(A0),       32'(e.a0 & !HOLD));
        chk({ph, ":W_ACK"},    32'(W_ACK),    32'(e.w_ack & !HOLD));
        chk({ph, ":B_ACK"},    32'(B_ACK),    32'(e.b_ack & !HOLD));
        chk({ph, ":D_IN"},     32'(D_IN),     32'(e.d_in));
        chk({ph, ":A_IN"},     32'(A_IN),     32'(e.a_in));
        chk({ph, ":BUSY"},     32'(BUSY),     32'(busy));
        chk({ph, ":LAST_GNT"}, 32'(LAST_GNT), 32'(m_last));
        chk({ph, ":TXN_CNT"},  32'(TXN_CNT),  32'(m_cnt));
    endtask

    // Entered at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic run_cycle(input string ph);
        #1;
        check_outputs(ph);
        @(posedge CLK);
        model_step();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        nRESET = 1'b0;
        model_reset();
        @(negedge CLK);
        nRESET = 1'b1;
    endtask

    initial begin
        bit sa_pat [10];
        bit st_pat [10];
        sa_pat = '{0, 1, 0, 0, 0, 0, 1, 0, 0, 0};
        st_pat = '{0, 0, 0, 1, 1, 0, 0, 0, 1, 1};

        W_REQ = 0; B_REQ = 0; B_ORDER = 0; HOLD = 0; W_DATA = '0; B_DATA = '0;
        w_pend = 0; b_pend = 0;
        nRESET = 1'b0;
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        #1;
        check_outputs("reset");
        @(negedge CLK);
        nRESET = 1'b1;

        // Single word write
        W_REQ = 1; W_DATA = 16'hBEEF;
        run_cycle("w_idle");
        #1;
        chk("word_sto_a", 32'(STO_A), 32'd1);
        chk("word_a_in",  32'(A_IN),  32'hBEEF);
        chk("word_ack",   32'(W_ACK), 32'd1);
        run_cycle("w_word");
        W_REQ = 0;
        #1;
        chk("word_cnt", 32'(TXN_CNT), 32'd1);
        run_cycle("w_after");

        // Byte pair, low byte first
        B_REQ = 1; B_DATA = 16'h1234; B_ORDER = 0;
        run_cycle("bl_idle");
        #1;
        chk("bl1_sto", 32'(STO),  32'd1);
        chk("bl1_a0",  32'(A0),   32'd0);
        chk("bl1_din", 32'(D_IN), 32'h0034);
        run_cycle("bl_b1");
        #1;
        chk("bl2_a0",  32'(A0),    32'd1);
        chk("bl2_din", 32'(D_IN),  32'h0012);
        chk("bl2_ack", 32'(B_ACK), 32'd1);
        run_cycle("bl_b2");
        B_REQ = 0;
        run_cycle("bl_after");

        // Byte pair, high byte first
        B_REQ = 1; B_DATA = 16'hA55A; B_ORDER = 1;
        run_cycle("bh_idle");
        #1;
        chk("bh1_a0",  32'(A0),   32'd1);
        chk("bh1_din", 32'(D_IN), 32'h00A5);
        run_cycle("bh_b1");
        #1;
        chk("bh2_a0",  32'(A0),   32'd0);
        chk("bh2_din", 32'(D_IN), 32'h005A);
        run_cycle("bh_b2");
        B_REQ = 0;
        run_cycle("bh_after");

        // HOLD for three cycles while in BYTE1
        B_REQ = 1; B_DATA = 16'(W_DATA ^ 16'h5AC3); B_ORDER = 0;
        run_cycle("hold_idle");
        HOLD = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_sto", 32'(STO),   32'd0);
            chk("hold_ack", 32'(B_ACK), 32'd0);
            run_cycle("hold_b1");
        end
        HOLD = 0;
        #1;
        chk("hold_rel_sto", 32'(STO), 32'd1);
        chk("hold_rel_a0",  32'(A0),  32'd0);
        run_cycle("hold_rel_b1");
        #1;
        chk("hold_rel_ack", 32'(B_ACK), 32'd1);
        run_cycle("hold_rel_b2");
        B_REQ = 0;
        run_cycle("hold_after");

        // Contention from reset: word, byte, word, byte
        do_reset();
        W_REQ = 1; W_DATA = 16'h0F0F; B_REQ = 1; B_DATA = 16'hC3A1; B_ORDER = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("rr_sto_a", 32'(STO_A), 32'(sa_pat[i]));
            chk("rr_sto",   32'(STO),   32'(st_pat[i]));
            chk("rr_excl",  32'(STO & STO_A), 32'd0);
            run_cycle("rr");
        end
        W_REQ = 0; B_REQ = 0;
        run_cycle("rr_after");

        // Asynchronous reset shortly into BYTE2
        B_REQ = 1; B_DATA = 16'h7E81; B_ORDER = 1;
        run_cycle("ar_idle");
        run_cycle("ar_b1_pre");
        #1;
        check_outputs("ar_b1");
        @(posedge CLK);
        model_step();
        #2;
        nRESET = 1'b0;
        model_reset();
        #1;
        chk("ar_sto",  32'(STO),     32'd0);
        chk("ar_a0",   32'(A0),      32'd0);
        chk("ar_din",  32'(D_IN),    32'd0);
        chk("ar_busy", 32'(BUSY),    32'd0);
        chk("ar_ack",  32'(B_ACK),   32'd0);
        chk("ar_cnt",  32'(TXN_CNT), 32'd0);
        @(negedge CLK);
        nRESET = 1'b1;
        W_REQ = 1; W_DATA = 16'h1357;
        run_cycle("ar_tie");
        #1;
        chk("ar_word_wins", 32'(STO_A), 32'd1);
        run_cycle("ar_word");
        W_REQ = 0;
        run_cycle("ar_idle2");
        run_cycle("ar_b1b");
        run_cycle("ar_b2b");
        B_REQ = 0;
        run_cycle("ar_done");

        // Random traffic with HOLD
        w_pend = 0; b_pend = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!w_pend && $urandom_range(2) == 0) begin
                w_pend = 1;
                W_DATA = 16'($urandom);
            end
            if (!b_pend && $urandom_range(2) == 0) begin
                b_pend = 1;
                B_DATA = 16'($urandom);
                B_ORDER = 1'($urandom_range(1));
            end
            W_REQ = w_pend;
            B_REQ = b_pend;
            HOLD = ($urandom_range(4) == 0);
            run_cycle("rand");
        end
        W_REQ = 0; B_REQ = 0; HOLD = 0;
        for (int i = 0; i < 4; i++) run_cycle("drain");

        // Counter wrap after 256 word transactions
        do_reset();
        W_REQ = 1; W_DATA = 16'h2468;
        for (int i = 0; i < 512; i++) begin
            if (i == 256) begin
                #1;
                chk("wrap_half", 32'(TXN_CNT), 32'd128);
            end
            run_cycle("wrap");
        end
        #1;
        chk("wrap_zero", 32'(TXN_CNT), 32'd0);
        W_REQ = 0;
        run_cycle("wrap_end");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mrsp_access_ctrl.md
# mrsp_access_ctrl

Access sequencer and arbiter for the 16-bit MRSP byte/word register. It shares the register between two requesters. The word requester loads all 16 bits through the STO_A/A_IN path in one strobe. The byte requester delivers a 16-bit value as two byte stores through the STO/A0/D_IN path. The block sits directly in front of the register, and its outputs drive the register's D_IN, A0, STO, STO_A and A_IN inputs.

## Interface
- CNT_W, 8, width of the completed-transaction counter.

- CLK  in  1  system clock, rising edge.
- nRESET  in  1  asynchronous, active-low reset.
- W_REQ  in  1  word-write request.
- W_DATA  in  16  word to write. Sampled at grant.
- W_ACK  out  1  one-cycle pulse during the word's store strobe.
- B_REQ  in  1  byte-pair write request.
- B_DATA  in  16  value to deliver as two bytes. Sampled at grant.
- B_ORDER  in  1  0 = low byte first, 1 = high byte first. Sampled at grant.
- B_ACK  out  1  one-cycle pulse during the second byte's store strobe.
- HOLD  in  1  freezes the sequencer and suppresses strobes and ACKs.
- D_IN  out  16  {8'h00, current byte}, to the register's D_IN.
- A0  out  1  byte select: 1 = high byte, 0 = low byte.
- STO  out  1  byte-store strobe.
- STO_A  out  1  full-word store strobe.
- A_IN  out  16  word data, to the register's A_IN.
- BUSY  out  1  high whenever the state is not IDLE.
- LAST_GNT  out  1  last granted requester: 0 = word, 1 = byte.
- TXN_CNT  out  CNT_W  count of completed transactions, wraps.

## Operation
- States: IDLE, WORD, BYTE1, BYTE2.
- Requests are sampled only in IDLE. Every transaction returns to IDLE for at least one cycle.
- Arbitration in IDLE:
  - Only W_REQ high: go to WORD and latch W_DATA. LAST_GNT <= 0.
  - Only B_REQ high: go to BYTE1 and latch B_DATA and B_ORDER. LAST_GNT <= 1.
  - Both high: round-robin. The requester not named by LAST_GNT wins.
- WORD:
  - STO_A = 1, A_IN = latched word, W_ACK = 1.
  - Next state IDLE.
- BYTE1:
  - STO = 1, A0 = B_ORDER.
  - D_IN[7:0] = high byte if A0 = 1, else low byte. D_IN[15:8] = 0.
  - Next state BYTE2.
- BYTE2:
  - STO = 1, A0 = ~B_ORDER, D_IN[7:0] = the other byte, B_ACK = 1.
  - Next state IDLE.
- STO and STO_A are never both high. Each ACK is exactly one cycle per transaction.
- Strobes, A0 and the ACKs are decoded from state and gated by ~HOLD.
- HOLD = 1:
  - No state advance, no arbitration, and the latched data is held.
  - STO = STO_A = W_ACK = B_ACK = 0.
  - Releasing HOLD resumes at the same state.
- D_IN and A_IN come from latched data registers. They are stable for the whole transaction and retain their last value in IDLE.
- A requester must hold its REQ until it sees its ACK. A REQ still high in the IDLE cycle after the ACK is treated as a new request.
- TXN_CNT increments at the clock edge that ends each ACK cycle, and wraps from 2^CNT_W-1 to 0.
- Reset (nRESET low, asynchronous, any state including mid-transaction):
  - State IDLE, LAST_GNT = 1, so the first tie goes to the word requester.
  - Latched data = 0, B_ORDER latch = 0, TXN_CNT = 0.
  - All outputs 0: D_IN, A_IN, A0, STO, STO_A, W_ACK, B_ACK, BUSY.
  - An interrupted transaction is dropped with no ACK. The register may already hold a first byte.

## Timing
- Word path:
  - Request sampled at edge E0.
  - STO_A and W_ACK are high during cycle E0–E1. The register captures at E1.
  - Minimum spacing between word transactions is 2 cycles.
- Byte path:
  - Request sampled at E0.
  - Strobes during E0–E1 and E1–E2. B_ACK is high in the second strobe cycle.
  - Minimum spacing between byte-pair transactions is 3 cycles.
- Each cycle with HOLD high adds one cycle to the transaction in progress.
- A0, D_IN and A_IN are valid for the whole strobe cycle, so setup to the capturing edge is met.

## Test plan
- Word write: W_REQ with W_DATA = 16'hBEEF from IDLE -> exactly one cycle of STO_A = 1, A_IN = 16'hBEEF, W_ACK = 1. TXN_CNT goes 0 -> 1.
- Byte write, low byte first: B_DATA = 16'h1234, B_ORDER = 0 ->
  - cycle 1: STO = 1, A0 = 0, D_IN = 16'h0034;
  - cycle 2: STO = 1, A0 = 1, D_IN = 16'h0012, B_ACK = 1.
- Byte write, high byte first: B_DATA = 16'hA55A, B_ORDER = 1 -> first cycle A0 = 1, D_IN = 16'h00A5; second cycle A0 = 0, D_IN = 16'h005A.
- Contention: W_REQ and B_REQ both held high from reset -> grants in order word, byte, word, byte. Every grant is separated by one IDLE cycle. STO and STO_A are never high together.
- HOLD in BYTE1 for 3 cycles -> STO = 0 and no ACK for those 3 cycles. On release, the BYTE1 strobe occurs, then BYTE2 with B_ACK = 1.
- Reset in BYTE2 with nRESET low mid-cycle -> STO, A0, D_IN and BUSY go to 0 immediately and B_ACK is never seen. After release, a new W_REQ wins, because a tie from reset grants the word requester.
- Counter wrap at CNT_W = 8: 256 back-to-back word transactions -> TXN_CNT returns to 0.
